// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution block: funct3 encodings,
// controller states and the default fall-through increment.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int INST_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2
  } state_t;

endpackage

// File: rtl/branchcomp.sv
// Branch condition comparator: evaluates a funct3 branch condition on two
// operands. Reserved encodings report not-taken.
module branchcomp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      funct3,
  output logic            taken
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic                   eq;
  logic                   lt_s;
  logic                   lt_u;

  assign a_s  = a;
  assign b_s  = b;
  assign eq   = (a == b);
  assign lt_s = (a_s < b_s);
  assign lt_u = (a < b);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: accepts a branch op, resolves it one cycle
// later, flags mispredicts and holds a redirect until fetch takes it.
// Optional counters enabled with BRANCH_RESOLVE_STATS_EN.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_BYTES = INST_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  input  logic            req_pred_taken,
  input  logic            kill,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic            res_illegal,
  output logic            res_misalign,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic [XLEN-1:0]   rs1_p0;
  logic [XLEN-1:0]   rs2_p0;
  logic [2:0]        funct3_p0;
  logic [XLEN-1:0]   pc_p0;
  logic [XLEN-1:0]   imm_p0;
  logic              pred_p0;
  logic              vld_p0;
  logic              cmp_taken;
  logic              illegal_p0;
  logic              misalign_p0;
  logic              taken_p0;
  logic [XLEN-1:0]   taken_tgt;
  logic [XLEN-1:0]   nt_tgt;
  logic [XLEN-1:0]   redir_tgt;

  assign accept = req_valid && req_ready;

  // Stage p0: capture the accepted op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_p0    <= '0;
      rs2_p0    <= '0;
      funct3_p0 <= '0;
      pc_p0     <= '0;
      imm_p0    <= '0;
      pred_p0   <= 1'b0;
    end else if (accept) begin
      rs1_p0    <= req_rs1;
      rs2_p0    <= req_rs2;
      funct3_p0 <= req_funct3;
      pc_p0     <= req_pc;
      imm_p0    <= req_imm;
      pred_p0   <= req_pred_taken;
    end
  end

  branchcomp #(.XLEN(XLEN)) u_cmp (
    .a      (rs1_p0),
    .b      (rs2_p0),
    .funct3 (funct3_p0),
    .taken  (cmp_taken)
  );

  assign vld_p0      = (state == EVAL);
  assign illegal_p0  = (funct3_p0[2:1] == 2'b01);
  assign taken_p0    = cmp_taken && !illegal_p0;
  assign taken_tgt   = pc_p0 + imm_p0;
  assign nt_tgt      = pc_p0 + XLEN'(INST_BYTES);
  assign misalign_p0 = taken_p0 && taken_tgt[1];
  // Capture registers stay untouched until IDLE, so this is stable through REDIR
  assign redir_tgt   = taken_p0 ? taken_tgt : nt_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    res_valid      = 1'b0;
    res_taken      = 1'b0;
    res_mispredict = 1'b0;
    res_illegal    = 1'b0;
    res_misalign   = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        req_ready = !kill && !rst;
        if (req_valid && !kill && !rst) state_nxt = EVAL;
      end
      EVAL: begin
        state_nxt = IDLE;
        if (!kill && vld_p0) begin
          res_valid      = 1'b1;
          res_taken      = taken_p0;
          res_illegal    = illegal_p0;
          res_misalign   = misalign_p0;
          res_mispredict = !illegal_p0 && !misalign_p0 && (taken_p0 != pred_p0);
          if (res_mispredict) begin
            flush          = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            if (!redirect_ready) state_nxt = REDIR;
          end
        end
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_tgt;
        if (kill || redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_valid && !illegal_p0) stat_branches <= sat_inc(stat_branches);
      if (flush)                    stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end
`endif

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences conditional-branch resolution for the core pipeline.
- Accepts one branch op per handshake and evaluates it one cycle later with the existing branchcomp comparator.
- Computes the taken/not-taken target and flags a mispredict against the fetch-stage prediction.
- On a mispredict, issues a flush pulse and holds a redirect request until fetch accepts it.

Parameters:
- XLEN, 32, operand and PC width.
- INST_BYTES, 4, fall-through increment added to PC for the not-taken path.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  branch op offered.
- req_ready  out  1  block can accept an op.
- req_rs1  in  XLEN  first compare operand.
- req_rs2  in  XLEN  second compare operand.
- req_funct3  in  3  branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU encoding).
- req_pc  in  XLEN  branch instruction PC.
- req_imm  in  XLEN  sign-extended B-immediate.
- req_pred_taken  in  1  fetch prediction.
- kill  in  1  squash any in-flight op (older exception or trap).
- res_valid  out  1  one-cycle result strobe.
- res_taken  out  1  actual outcome.
- res_mispredict  out  1  outcome differs from prediction.
- res_illegal  out  1  funct3 is 010 or 011.
- res_misalign  out  1  taken target has bit1 set.
- flush  out  1  one-cycle pulse; younger instructions must be discarded.
- redirect_valid  out  1  fetch must restart at redirect_pc.
- redirect_pc  out  XLEN  restart address.
- redirect_ready  in  1  fetch accepts the redirect.

Behaviour:
- Reset: all outputs 0, req_ready 0 while rst is high, state IDLE, capture registers 0.
- States: IDLE, EVAL, REDIR.
- IDLE:
  - req_ready = !kill.
  - On req_valid && req_ready, capture rs1, rs2, funct3, pc, imm and pred, then go to EVAL.
- EVAL (always exactly one cycle; latency is 1 cycle from acceptance to res_valid):
  - res_valid = 1 unless kill.
  - Compare the captured operands through branchcomp. Signed compares for 100/101, unsigned for 110/111.
  - Targets: taken_tgt = pc + imm and nt_tgt = pc + INST_BYTES, both modulo 2^XLEN (wrap silently).
  - Illegal funct3: res_illegal = 1, taken = 0, mispredict = 0, no flush or redirect.
  - Taken with taken_tgt[1] = 1: res_misalign = 1, mispredict = 0, no flush or redirect; the trap is raised elsewhere.
  - Otherwise mispredict = (taken != pred).
  - On mispredict:
    - flush = 1 for this cycle.
    - redirect_valid = 1, with redirect_pc = taken ? taken_tgt : nt_tgt.
    - If redirect_ready is high the same cycle, go to IDLE; otherwise go to REDIR.
  - No mispredict: go to IDLE.
  - res_* flags are valid only while res_valid = 1 and are 0 otherwise.
- REDIR:
  - Hold redirect_valid = 1 with redirect_pc stable. flush stays 0; it is never repeated.
  - Go to IDLE on redirect_ready.
- kill:
  - In EVAL: suppress res_valid, flush and redirect, and go to IDLE.
  - In REDIR: drop redirect_valid next cycle and go to IDLE.
  - Kill has priority over every other event.
- Throughput: at most one op per 2 cycles, since req_ready is 0 in EVAL and REDIR. A held req_valid is accepted on the cycle the block returns to IDLE.
- Asserting rst mid-operation returns to IDLE immediately and clears all outputs asynchronously.

Optional Feature:
- Macro BRANCH_RESOLVE_STATS_EN.
- When defined, adds output ports stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches counts non-killed EVAL cycles with a legal funct3.
  - stat_mispredicts counts the flush pulses.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, the ports and logic are absent and all other behaviour is identical.

Decomposition:
- Shared package branch_pkg:
  - funct3 localparams F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111.
  - State enum values IDLE/EVAL/REDIR.
  - The INST_BYTES default.
- Single sub-module: the existing branchcomp comparator, instantiated once on the captured operands. No other hierarchy.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> res_valid 1 cycle after accept; taken=1, mispredict=1, flush pulse, redirect_pc=0x120 accepted same cycle.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken=1, no mispredict, no flush. BLTU with the same operands, pred=1 -> taken=0, mispredict, redirect_pc=pc+4.
- Mispredict with redirect_ready held low 3 cycles -> redirect_valid and redirect_pc stable for 4 cycles, flush only in the first, req_ready 0 throughout.
- kill asserted in EVAL of a mispredicting BNE -> no res_valid, no flush, no redirect, back in IDLE next cycle. kill together with req_valid in IDLE -> request not accepted.
- funct3=010 -> res_illegal=1, no redirect. pc=0xFFFFFFF0 with imm=0x20 taken -> redirect_pc=0x10 (wrap). imm=0x22 taken -> res_misalign=1, no redirect.
- rst pulsed during REDIR -> redirect_valid drops asynchronously to 0. With BRANCH_RESOLVE_STATS_EN, stats read 0 after reset and count 3/2 after 3 legal branches with 2 mispredicts.
